// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared constants and state encoding for the data-memory responder
// Purpose: default geometry, error pattern, counter width and FSM encoding.
// Ports: none (package).
package dmem_responder_pkg;

    localparam logic [31:0] DMEM_BASE     = 32'h8000_0000;
    localparam int          DMEM_DEPTH    = 4096;
    localparam logic [31:0] DMEM_ERR_DATA = 32'hDEAD_BEEF;
    localparam int          CNT_W         = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

endpackage

// File: rtl/dmem_responder_if.sv
// rtl/dmem_responder_if.sv - mem_* request/response bundle between execute stage and responder
// Purpose: groups the request and response signals of the data-memory port.
// Ports: none; master modport drives requests, slave modport drives responses.
interface dmem_responder_if;

    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic [3:0]  mem_we_mask_i;
    logic        mem_wen_i;
    logic        mem_ren_i;
    logic        mem_ready_o;
    logic        mem_rvalid_o;
    logic [31:0] mem_rdata_o;
    logic        mem_err_o;

    modport master (
        output mem_addr_i, mem_wdata_i, mem_we_mask_i, mem_wen_i, mem_ren_i,
        input  mem_ready_o, mem_rvalid_o, mem_rdata_o, mem_err_o
    );

    modport slave (
        input  mem_addr_i, mem_wdata_i, mem_we_mask_i, mem_wen_i, mem_ren_i,
        output mem_ready_o, mem_rvalid_o, mem_rdata_o, mem_err_o
    );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word-addressed 32-bit storage with byte-lane write enables
// Purpose: DEPTH_WORDS x 32 array, asynchronous read, synchronous byte-masked write.
// Ports: clk_i clock; we_i per-byte write enables; idx_i word index;
//        wdata_i lane-aligned write data; rdata_o word at idx_i.
module dmem_array #(
    parameter int DEPTH_WORDS = 4096,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk_i,
    input  logic [3:0]       we_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [31:0]      wdata_i,
    output logic [31:0]      rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk_i) begin
        for (int b = 0; b < 4; b++) begin
            if (we_i[b]) begin
                mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - memory-side responder for single outstanding load/store requests
// Purpose: accepts a request while idle, waits LATENCY cycles, writes/reads the array and
//          returns a one-cycle response with read data and an error flag.
// Ports: clk_i clock; rst_i synchronous active-high reset;
//        mem slave side of dmem_responder_if (request in, ready/rvalid/rdata/err out).
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = DMEM_DEPTH,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] ERR_DATA    = DMEM_ERR_DATA
) (
    input  logic            clk_i,
    input  logic            rst_i,
    dmem_responder_if.slave mem
);

    localparam int               IDX_W    = $clog2(DEPTH_WORDS);
    localparam bit               LAT_ONE  = (LATENCY == 1);
    localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(LATENCY - 1);
    localparam logic [31:0]      SPAN_B   = 32'(DEPTH_WORDS) << 2;

    dmem_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [3:0]       mask_q, mask_d;
    logic             wen_q, wen_d;
    logic             ren_q, ren_d;
    logic             rvalid_q, rvalid_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic             idle, accept, enter_resp;
    logic [31:0]      req_addr, req_wdata;
    logic [3:0]       req_mask;
    logic             req_wen, req_ren, req_err, borrow;
    logic [31:0]      diff;
    logic [IDX_W-1:0] idx;
    logic [3:0]       arr_we;
    logic [31:0]      arr_rdata;

    dmem_array #(.DEPTH_WORDS(DEPTH_WORDS), .IDX_W(IDX_W)) u_array (
        .clk_i   (clk_i),
        .we_i    (arr_we),
        .idx_i   (idx),
        .wdata_i (req_wdata),
        .rdata_o (arr_rdata)
    );

    always_comb begin
        idle   = (state_q == ST_IDLE);
        accept = idle && (mem.mem_wen_i || mem.mem_ren_i);

        // With LATENCY==1 the array is accessed on the accept edge itself, before the
        // request is latched, so decode works on the live inputs while idle.
        req_addr  = idle ? mem.mem_addr_i    : addr_q;
        req_wdata = idle ? mem.mem_wdata_i   : wdata_q;
        req_mask  = idle ? mem.mem_we_mask_i : mask_q;
        req_wen   = idle ? mem.mem_wen_i     : wen_q;
        req_ren   = idle ? mem.mem_ren_i     : ren_q;

        // 33-bit subtract: the top bit is the borrow, i.e. addr below the base.
        {borrow, diff} = {1'b0, req_addr} - {1'b0, BASE_ADDR};
        idx     = diff[IDX_W+1:2];
        req_err = borrow || (diff >= SPAN_B) || (req_wen && req_ren);

        enter_resp = (accept && LAT_ONE) || (state_q == ST_WAIT && cnt_q == CNT_W'(1));

        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        wen_d    = wen_q;
        ren_d    = ren_q;
        rvalid_d = 1'b0;
        rdata_d  = 32'h0;
        err_d    = 1'b0;
        arr_we   = 4'h0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = mem.mem_addr_i;
                    wdata_d = mem.mem_wdata_i;
                    mask_d  = mem.mem_we_mask_i;
                    wen_d   = mem.mem_wen_i;
                    ren_d   = mem.mem_ren_i;
                    if (LAT_ONE) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (enter_resp) begin
            rvalid_d = 1'b1;
            err_d    = req_err;
            if (req_err) begin
                rdata_d = ERR_DATA;
            end else if (req_ren) begin
                rdata_d = arr_rdata;
            end
            // A reset on the same edge discards the request, including its write.
            if (req_wen && !req_err && !rst_i) begin
                arr_we = req_mask;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            mask_q   <= '0;
            wen_q    <= 1'b0;
            ren_q    <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            wen_q    <= wen_d;
            ren_q    <= ren_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    assign mem.mem_ready_o  = idle;
    assign mem.mem_rvalid_o = rvalid_q;
    assign mem.mem_rdata_o  = rdata_q;
    assign mem.mem_err_o    = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder at latencies 1, 3 and 4
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] addr_s  [3];
    logic [31:0] wdata_s [3];
    logic [3:0]  mask_s  [3];
    logic        wen_s   [3];
    logic        ren_s   [3];
    logic        rst_s   [3];
    logic        rdy     [3];
    logic        rv      [3];
    logic [31:0] rdat    [3];
    logic        errs    [3];

    int rv_cnt [3] = '{0, 0, 0};
    int pass_cnt = 0;
    int chk_cnt  = 0;

    dmem_responder_if u_if0 ();
    dmem_responder_if u_if1 ();
    dmem_responder_if u_if2 ();

    assign u_if0.mem_addr_i = addr_s[0];  assign u_if0.mem_wdata_i = wdata_s[0];
    assign u_if0.mem_we_mask_i = mask_s[0]; assign u_if0.mem_wen_i = wen_s[0];
    assign u_if0.mem_ren_i = ren_s[0];
    assign u_if1.mem_addr_i = addr_s[1];  assign u_if1.mem_wdata_i = wdata_s[1];
    assign u_if1.mem_we_mask_i = mask_s[1]; assign u_if1.mem_wen_i = wen_s[1];
    assign u_if1.mem_ren_i = ren_s[1];
    assign u_if2.mem_addr_i = addr_s[2];  assign u_if2.mem_wdata_i = wdata_s[2];
    assign u_if2.mem_we_mask_i = mask_s[2]; assign u_if2.mem_wen_i = wen_s[2];
    assign u_if2.mem_ren_i = ren_s[2];

    assign rdy[0] = u_if0.mem_ready_o; assign rv[0] = u_if0.mem_rvalid_o;
    assign rdat[0] = u_if0.mem_rdata_o; assign errs[0] = u_if0.mem_err_o;
    assign rdy[1] = u_if1.mem_ready_o; assign rv[1] = u_if1.mem_rvalid_o;
    assign rdat[1] = u_if1.mem_rdata_o; assign errs[1] = u_if1.mem_err_o;
    assign rdy[2] = u_if2.mem_ready_o; assign rv[2] = u_if2.mem_rvalid_o;
    assign rdat[2] = u_if2.mem_rdata_o; assign errs[2] = u_if2.mem_err_o;

    dmem_responder #(.LATENCY(1)) u_dut_l1 (.clk_i(clk), .rst_i(rst_s[0]), .mem(u_if0.slave));
    dmem_responder #(.LATENCY(3)) u_dut_l3 (.clk_i(clk), .rst_i(rst_s[1]), .mem(u_if1.slave));
    dmem_responder #(.LATENCY(4)) u_dut_l4 (.clk_i(clk), .rst_i(rst_s[2]), .mem(u_if2.slave));

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (rv[k] === 1'b1) rv_cnt[k]++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input int k, input logic w, input logic r, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] m);
        wen_s[k] = w; ren_s[k] = r; addr_s[k] = a; wdata_s[k] = d; mask_s[k] = m;
    endtask

    task automatic release_bus(input int k);
        drive(k, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    // Waits for ready, presents one request for one cycle and waits for its response.
    task automatic do_req(input int k, input logic w, input logic r, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] m,
                          output logic [31:0] rd, output logic e, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (rdy[k] !== 1'b1) check("ready_timeout", {31'h0, rdy[k]}, 32'h1);
        drive(k, w, r, a, d, m);
        @(negedge clk);
        release_bus(k);
        lat = 1;
        while (rv[k] !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        if (rv[k] !== 1'b1) check("rvalid_timeout", {31'h0, rv[k]}, 32'h1);
        rd = rdat[k];
        e  = errs[k];
    endtask

    logic [31:0] rd;
    logic        e;
    int          lat;
    int          c0;

    initial begin
        for (int k = 0; k < 3; k++) begin
            release_bus(k);
            rst_s[k] = 1'b1;
        end
        @(negedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) rst_s[k] = 1'b0;
        check("rst_ready_l1", {31'h0, rdy[0]}, 32'h1);
        check("rst_ready_l3", {31'h0, rdy[1]}, 32'h1);
        check("rst_ready_l4", {31'h0, rdy[2]}, 32'h1);
        check("rst_rvalid", {31'h0, rv[0]}, 32'h0);
        check("rst_rdata", rdat[0], 32'h0);
        check("rst_err", {31'h0, errs[0]}, 32'h0);

        // Basic store then load at LATENCY=1
        do_req(0, 1, 0, 32'h8000_0010, 32'h1234_5678, 4'hF, rd, e, lat);
        check("t1_st_lat", lat, 1);
        check("t1_st_err", {31'h0, e}, 32'h0);
        check("t1_st_rdata", rd, 32'h0);
        do_req(0, 0, 1, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
        check("t1_ld_lat", lat, 1);
        check("t1_ld_rdata", rd, 32'h1234_5678);
        check("t1_ld_err", {31'h0, e}, 32'h0);

        // Byte lanes, and a zero mask that acks without writing
        do_req(0, 1, 0, 32'h8000_0020, 32'hAABB_CCDD, 4'hF, rd, e, lat);
        do_req(0, 1, 0, 32'h8000_0020, 32'h0000_EE00, 4'b0010, rd, e, lat);
        do_req(0, 0, 1, 32'h8000_0020, 32'h0, 4'h0, rd, e, lat);
        check("t2_lane_rdata", rd, 32'hAABB_EEDD);
        do_req(0, 1, 0, 32'h8000_0020, 32'h1111_1111, 4'h0, rd, e, lat);
        check("t2_mask0_err", {31'h0, e}, 32'h0);
        do_req(0, 0, 1, 32'h8000_0020, 32'h0, 4'h0, rd, e, lat);
        check("t2_mask0_rdata", rd, 32'hAABB_EEDD);

        // Errors
        do_req(0, 1, 0, 32'h8000_0000, 32'h0BAD_F00D, 4'hF, rd, e, lat);
        do_req(0, 0, 1, 32'h7FFF_FFFC, 32'h0, 4'h0, rd, e, lat);
        check("t4_below_err", {31'h0, e}, 32'h1);
        check("t4_below_rdata", rd, 32'hDEAD_BEEF);
        do_req(0, 1, 0, 32'h8000_4000, 32'h5555_5555, 4'hF, rd, e, lat);
        check("t4_above_err", {31'h0, e}, 32'h1);
        do_req(0, 0, 1, 32'h8000_0000, 32'h0, 4'h0, rd, e, lat);
        check("t4_above_nowrite", rd, 32'h0BAD_F00D);
        do_req(0, 1, 1, 32'h8000_0010, 32'h9999_9999, 4'hF, rd, e, lat);
        check("t4_both_err", {31'h0, e}, 32'h1);
        do_req(0, 0, 1, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
        check("t4_both_nowrite", rd, 32'h1234_5678);
        do_req(0, 1, 0, 32'h8000_3FFC, 32'hC0DE_0001, 4'hF, rd, e, lat);
        check("t4_last_err", {31'h0, e}, 32'h0);
        do_req(0, 0, 1, 32'h8000_3FFC, 32'h0, 4'h0, rd, e, lat);
        check("t4_last_rdata", rd, 32'hC0DE_0001);

        // LATENCY=3 timing, and a request ignored while busy
        do_req(1, 1, 0, 32'h8000_0010, 32'h1111_2222, 4'hF, rd, e, lat);
        check("t3_st_lat", lat, 3);
        @(negedge clk);
        c0 = rv_cnt[1];
        check("t3_ready_t", {31'h0, rdy[1]}, 32'h1);
        drive(1, 0, 1, 32'h8000_0010, 32'h0, 4'h0);
        @(negedge clk);
        release_bus(1);
        check("t3_ready_t1", {31'h0, rdy[1]}, 32'h0);
        check("t3_rvalid_t1", {31'h0, rv[1]}, 32'h0);
        @(negedge clk);
        check("t3_ready_t2", {31'h0, rdy[1]}, 32'h0);
        check("t3_rvalid_t2", {31'h0, rv[1]}, 32'h0);
        drive(1, 1, 0, 32'h8000_0010, 32'hCAFE_F00D, 4'hF);
        @(negedge clk);
        release_bus(1);
        check("t3_ready_t3", {31'h0, rdy[1]}, 32'h0);
        check("t3_rvalid_t3", {31'h0, rv[1]}, 32'h1);
        check("t3_rdata_t3", rdat[1], 32'h1111_2222);
        @(negedge clk);
        check("t3_rvalid_t4", {31'h0, rv[1]}, 32'h0);
        check("t3_ready_t4", {31'h0, rdy[1]}, 32'h1);
        repeat (6) @(negedge clk);
        check("t3_ignored_resp", rv_cnt[1] - c0, 1);
        do_req(1, 0, 1, 32'h8000_0010, 32'h0, 4'h0, rd, e, lat);
        check("t3_ignored_nowrite", rd, 32'h1111_2222);

        // Reset in the middle of a LATENCY=4 store
        do_req(2, 1, 0, 32'h8000_0000, 32'h0, 4'hF, rd, e, lat);
        check("t5_st_lat", lat, 4);
        @(negedge clk);
        c0 = rv_cnt[2];
        drive(2, 1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 4'hF);
        @(negedge clk);
        release_bus(2);
        @(negedge clk);
        rst_s[2] = 1'b1;
        @(negedge clk);
        rst_s[2] = 1'b0;
        check("t5_ready_after_rst", {31'h0, rdy[2]}, 32'h1);
        check("t5_rvalid_after_rst", {31'h0, rv[2]}, 32'h0);
        repeat (6) @(negedge clk);
        check("t5_no_resp", rv_cnt[2] - c0, 0);
        do_req(2, 0, 1, 32'h8000_0000, 32'h0, 4'h0, rd, e, lat);
        check("t5_nowrite", rd, 32'h0);

        // Back-to-back store/load pairs at LATENCY=1
        @(negedge clk);
        c0 = rv_cnt[0];
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, d;
            a = 32'h8000_0100 + 32'(4 * i);
            d = 32'h0101_0101 * 32'(i + 1) ^ 32'h5A00_00A5;
            do_req(0, 1, 0, a, d, 4'hF, rd, e, lat);
            do_req(0, 0, 1, a, 32'h0, 4'h0, rd, e, lat);
            check($sformatf("t6_pair%0d", i), rd, d);
        end
        @(negedge clk);
        check("t6_rvalid_count", rv_cnt[0] - c0, 16);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

endmodule
